// File: rtl/dm_byte_lane.sv
// dm_byte_lane: MEM-stage data memory built from four byte-lane arrays.
// Word/half/byte stores use per-lane enables. Sub-word loads are sign- or
// zero-extended and have zero latency.
// Misaligned, out-of-range and illegal-op accesses raise addr_exc. A store
// that raises addr_exc is dropped.
// After reset, a clear engine zeroes one word per cycle. The memory reports
// busy until every word has been cleared.
// Optional store logging: define DM_LOG_EN.
module dm_byte_lane #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              mem_write,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr_byte,
  input  logic [31:0]       mem_data,
  output logic [31:0]       dm_out,
  output logic              addr_exc,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  clr_ptr_reg, clr_ptr_next;

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  rd_idx;
  logic              ready;
  logic              out_of_range;
  logic              misaligned;
  logic              illegal_op;
  logic              exc;
  logic              st_en;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [15:0]       rd_half;
  logic [7:0]        rd_byte;

  assign word_idx = mem_addr_byte[ADDR_W-1:2];
  assign lane     = mem_addr_byte[1:0];
  // An out-of-range index aliases here, but its read data is masked and its
  // write is suppressed.
  assign rd_idx   = word_idx[IDX_W-1:0];
  assign ready    = (state_reg == READY);
  assign busy     = ~ready;

  // Clear-engine state register; reset restarts the clear from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Next state: walk clr_ptr across all words, then enter READY.
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      CLEAR: begin
        if (clr_ptr_reg == LAST_IDX) begin
          state_next   = READY;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + IDX_W'(1);
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Exception detection. It applies to loads and stores alike, and only in READY.
  always_comb begin
    out_of_range = (ADDR_W'(word_idx) >= DEPTH_V);
    misaligned   = 1'b0;
    illegal_op   = 1'b0;
    case (mem_op)
      OP_W:        misaligned = (lane != 2'b00);
      OP_H, OP_HU: misaligned = lane[0];
      OP_B, OP_BU: misaligned = 1'b0;
      default:     illegal_op = 1'b1;
    endcase
    exc = ready & (out_of_range | misaligned | illegal_op);
  end

  assign addr_exc = exc;
  assign st_en    = ready & mem_write & ~exc;

  // Lane enables. Store data is replicated so each lane sees its own slice.
  always_comb begin
    be    = 4'b0000;
    wdata = mem_data;
    case (mem_op)
      OP_H, OP_HU: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_data[15:0]}};
      end
      OP_B, OP_BU: begin
        be    = 4'b0001 << lane;
        wdata = {4{mem_data[7:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = mem_data;
      end
    endcase
  end

  // One byte-wide array per lane. Reads are asynchronous, so loads see the
  // current contents and a same-cycle store shows up from the next cycle on.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Lane write: the clear engine has priority while in CLEAR.
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (state_reg == CLEAR) begin
          mem[clr_ptr_reg] <= 8'h00;
        end else if (st_en && be[gi]) begin
          mem[rd_idx] <= wdata[gi*8 +: 8];
        end
      end
    end

    assign rd_word[gi*8 +: 8] = mem[rd_idx];
  end

  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];

  // Load formatting: extend the selected sub-word, and return zero when busy
  // or on an exception.
  always_comb begin
    dm_out = 32'h0;
    if (ready && !exc) begin
      case (mem_op)
        OP_W:    dm_out = rd_word;
        OP_H:    dm_out = {{16{rd_half[15]}}, rd_half};
        OP_HU:   dm_out = {16'h0, rd_half};
        OP_B:    dm_out = {{24{rd_byte[7]}}, rd_byte};
        OP_BU:   dm_out = {24'h0, rd_byte};
        default: dm_out = 32'h0;
      endcase
    end
  end

`ifdef DM_LOG_EN
  logic [31:0] merged;

  // Post-store word image: new bytes in enabled lanes, old bytes elsewhere.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  // Log each performed store with its word-aligned byte address.
  always @(posedge clk) begin
    if (!reset && st_en) begin
      $display("@%h: *%h <= %h", pc, 32'({word_idx, 2'b00}), merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_byte_lane.sv
// tb_dm_byte_lane: directed and randomized checks of dm_byte_lane against a
// word-array reference model (DEPTH=16, ADDR_W=8).
module tb_dm_byte_lane;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       pc = '0;
  logic              mem_write = 1'b0;
  logic [2:0]        mem_op = '0;
  logic [ADDR_W-1:0] mem_addr_byte = '0;
  logic [31:0]       mem_data = '0;
  logic [31:0]       dm_out;
  logic              addr_exc;
  logic              busy;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          m_busy = 1'b1;
  logic [31:0] last_dm;
  logic        last_exc;

  dm_byte_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .mem_write(mem_write),
    .mem_op(mem_op), .mem_addr_byte(mem_addr_byte), .mem_data(mem_data),
    .dm_out(dm_out), .addr_exc(addr_exc), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_exc(input int op, input int addr);
    int idx = addr / 4;
    int ln  = addr % 4;
    if (m_busy) return 1'b0;
    if (idx >= DEPTH || op > 4) return 1'b1;
    if (op == 0 && ln != 0) return 1'b1;
    if ((op == 1 || op == 2) && (ln % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input int op, input int addr);
    logic [31:0] w, v;
    int ln = addr % 4;
    if (m_busy || exp_exc(op, addr)) return 32'h0;
    w = ref_mem[addr / 4];
    v = 32'h0;
    case (op)
      0: v = w;
      1, 2: begin
        v = (w >> (16 * (ln / 2))) & 32'hFFFF;
        if (op == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      3, 4: begin
        v = (w >> (8 * ln)) & 32'hFF;
        if (op == 3 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_store(input int op, input int addr, input logic [31:0] data);
    int idx = addr / 4;
    int ln  = addr % 4;
    int sh;
    if (op == 0) begin
      ref_mem[idx] = data;
    end else if (op == 1 || op == 2) begin
      sh = 16 * (ln / 2);
      ref_mem[idx] = (ref_mem[idx] & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
    end else begin
      sh = 8 * ln;
      ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
    end
  endtask

  // One access: drive at negedge, check outputs 1 time unit later, update the
  // model so it matches the commit at the next posedge.
  task automatic access(input string tag, input int op, input int addr,
                        input logic [31:0] data, input bit we);
    bit          e_exc;
    logic [31:0] e_dm;
    @(negedge clk);
    mem_op        = 3'(op);
    mem_addr_byte = ADDR_W'(addr);
    mem_data      = data;
    mem_write     = we;
    pc            = $urandom;
    #1;
    e_exc = exp_exc(op, addr);
    e_dm  = exp_load(op, addr);
    check({tag, "_busy"}, 32'(busy), 32'(m_busy));
    check({tag, "_exc"}, 32'(addr_exc), 32'(e_exc));
    check({tag, "_dm"}, dm_out, e_dm);
    last_dm  = dm_out;
    last_exc = addr_exc;
    $display("access %s op=%0d addr=%h we=%0d data=%h -> dm_out=%h addr_exc=%0d",
             tag, op, addr, we, data, dm_out, addr_exc);
    if (we && !e_exc && !m_busy) model_store(op, addr, data);
  endtask

  task automatic idle();
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  // Assert reset between edges; busy must rise at once because reset is asynchronous.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    mem_write = 1'b0;
    #1 reset = 1'b1;
    m_busy = 1'b1;
    #1;
    check({tag, "_rst_busy"}, 32'(busy), 32'd1);
    check({tag, "_rst_dm"}, dm_out, 32'h0);
    check({tag, "_rst_exc"}, 32'(addr_exc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Count busy cycles after reset release; the clear must take exactly DEPTH.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check({tag, "_clear_cycles"}, 32'(cnt), 32'(DEPTH));
    $display("clear %s busy_cycles=%0d", tag, cnt);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    m_busy = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    check("init_busy", 32'(busy), 32'd1);
    check("init_dm", dm_out, 32'h0);
    reset = 1'b0;
    #1;
    wait_clear("init");

    // T1: word 5 nonzero, reset, reads back 0
    access("t1_sw", 0, 'h14, 32'h5A5A5A5A, 1);
    access("t1_lw_pre", 0, 'h14, 32'h0, 0);
    check("t1_pre_val", last_dm, 32'h5A5A5A5A);
    pulse_reset("t1");
    wait_clear("t1");
    access("t1_lw", 0, 'h14, 32'h0, 0);
    check("t1_zero", last_dm, 32'h0);

    // T2
    access("t2_sw", 0, 'h10, 32'h11223344, 1);
    access("t2_lw", 0, 'h10, 32'h0, 0);
    check("t2_lw_val", last_dm, 32'h11223344);
    access("t2_lb", 3, 'h13, 32'h0, 0);
    check("t2_lb_val", last_dm, 32'h00000011);
    access("t2_lh", 1, 'h12, 32'h0, 0);
    check("t2_lh_val", last_dm, 32'h00001122);
    access("t2_lbu", 4, 'h10, 32'h0, 0);
    check("t2_lbu_val", last_dm, 32'h00000044);

    // T3
    access("t3_sw", 0, 'h20, 32'h0, 1);
    access("t3_sb", 3, 'h21, 32'h00000080, 1);
    access("t3_sh", 1, 'h22, 32'h0000BEEF, 1);
    access("t3_lw", 0, 'h20, 32'h0, 0);
    check("t3_lw_val", last_dm, 32'hBEEF8000);
    access("t3_lb", 3, 'h21, 32'h0, 0);
    check("t3_lb_val", last_dm, 32'hFFFFFF80);
    access("t3_lhu", 2, 'h22, 32'h0, 0);
    check("t3_lhu_val", last_dm, 32'h0000BEEF);

    // T4
    access("t4_sw_mis", 0, 'h22, 32'h12345678, 1);
    check("t4_sw_exc", 32'(last_exc), 32'd1);
    access("t4_sh_mis", 1, 'h23, 32'h0000ABCD, 1);
    check("t4_sh_exc", 32'(last_exc), 32'd1);
    access("t4_op7", 7, 'h20, 32'hFFFFFFFF, 1);
    check("t4_op7_exc", 32'(last_exc), 32'd1);
    access("t4_lw", 0, 'h20, 32'h0, 0);
    check("t4_unchanged", last_dm, 32'hBEEF8000);
    access("t4_lh_mis", 1, 'h23, 32'h0, 0);
    check("t4_lh_dm", last_dm, 32'h0);

    // T5: out of range; index 16 would alias word 0
    access("t5_sw0", 0, 'h0, 32'hA5A5C3C3, 1);
    access("t5_sw_oor", 0, 'h40, 32'h99999999, 1);
    check("t5_exc", 32'(last_exc), 32'd1);
    access("t5_lw0", 0, 'h0, 32'h0, 0);
    check("t5_word0", last_dm, 32'hA5A5C3C3);

    // T6: store, reset, store while busy, reset again mid-clear
    access("t6_sw", 0, 'h8, 32'hDEADBEEF, 1);
    pulse_reset("t6a");
    for (int i = 0; i < 7; i++) access("t6_busy_sw", 0, 'h8, 32'hCAFEF00D, 1);
    pulse_reset("t6b");
    wait_clear("t6");
    access("t6_lw", 0, 'h8, 32'h0, 0);
    check("t6_word2", last_dm, 32'h0);

    // Randomized accesses, including out-of-range and illegal ops
    for (int i = 0; i < 300; i++) begin
      access("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 4 * DEPTH + 15)),
             $urandom, bit'($urandom_range(0, 1)));
    end
    idle();
    for (int a = 0; a < DEPTH; a++) access("final_lw", 0, 4 * a, 32'h0, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
